// File: rtl/htif_host_bridge.sv
// htif_host_bridge
//   Host-side framing stage in front of the HTIF nibble engine. It collects
//   a whole host packet (bytes) into a local buffer and then streams it to
//   HTIF as gap-free 4-bit nibbles, low nibble first. HTIF's nibble response
//   is reassembled into bytes for the host. Only one packet is outstanding
//   at a time, and the per-command request/response lengths decide when a
//   packet is complete.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   host_in_val/data/rdy     host request bytes (bridge is the sink)
//   host_out_val/data/rdy    response bytes to the host (bridge is the source)
//   nib_out_val/bits/rdy     request nibbles to HTIF (in_val/in_bits/in_rdy)
//   nib_in_val/bits/rdy      response nibbles from HTIF (out_val/out_bits/out_rdy)
//   htif_error               HTIF error; the bridge goes quiet until rst
//   bad_cmd                  sticky: an unknown command byte was dropped
//   timeout                  sticky: a partial packet was discarded
//   busy                     bridge is not collecting a new packet
module htif_host_bridge #(
  parameter int unsigned MAX_PKT_BYTES  = 21,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_in_val,
  input  logic [7:0] host_in_data,
  output logic       host_in_rdy,
  output logic       host_out_val,
  output logic [7:0] host_out_data,
  input  logic       host_out_rdy,
  output logic       nib_out_val,
  output logic [3:0] nib_out_bits,
  input  logic       nib_out_rdy,
  input  logic       nib_in_val,
  input  logic [3:0] nib_in_bits,
  output logic       nib_in_rdy,
  input  logic       htif_error,
  output logic       bad_cmd,
  output logic       timeout,
  output logic       busy
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    COLLECT,
    ARM,
    STREAM,
    RESP
  } state_t;

  state_t            state;
  logic [7:0]        pkt_buf [MAX_PKT_BYTES];
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  in_len;
  logic [CNT_W-1:0]  resp_len;
  logic [CNT_W-1:0]  rcnt;
  logic [CNT_W:0]    idx;
  logic [CNT_W:0]    last_idx;
  logic [IDLE_W-1:0] idle;
  logic              err;
  logic              in_rdy;
  logic              bad_cmd_q;
  logic              timeout_q;

  // response assembler
  logic [3:0]        lo_nib;
  logic              have_lo;
  logic [7:0]        out_data;
  logic              out_val;

  // command length lookup
  logic [CNT_W-1:0]  lut_in;
  logic [CNT_W-1:0]  lut_resp;
  logic              lut_ok;

  logic              in_fire;
  logic              out_fire;
  logic              nib_fire;
  logic [7:0]        cur_byte;

  assign in_fire  = host_in_val && in_rdy;
  assign out_fire = out_val && host_out_rdy;
  assign nib_fire = nib_in_val && nib_in_rdy;
  assign last_idx = {in_len, 1'b0} - (CNT_W + 1)'(1);

  always_comb begin
    lut_in   = '0;
    lut_resp = '0;
    lut_ok   = 1'b1;
    case (host_in_data)
      8'd0: begin lut_in = CNT_W'(5);  lut_resp = CNT_W'(17); end
      8'd1: begin lut_in = CNT_W'(21); lut_resp = CNT_W'(1);  end
      8'd2: begin lut_in = CNT_W'(5);  lut_resp = CNT_W'(5);  end
      8'd3: begin lut_in = CNT_W'(9);  lut_resp = CNT_W'(1);  end
      8'd4: begin lut_in = CNT_W'(5);  lut_resp = CNT_W'(1);  end
      8'd5: begin lut_in = CNT_W'(1);  lut_resp = CNT_W'(1);  end
      default: lut_ok = 1'b0;
    endcase
  end

  // The packet buffer is pure storage and carries no reset; the counters
  // decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (!rst && !err && !htif_error && state == COLLECT && in_fire) begin
      if (cnt != '0) begin
        pkt_buf[cnt] <= host_in_data;
      end else if (lut_ok) begin
        pkt_buf[0] <= host_in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      cnt       <= '0;
      in_len    <= '0;
      resp_len  <= '0;
      rcnt      <= '0;
      idx       <= '0;
      idle      <= '0;
      err       <= 1'b0;
      in_rdy    <= 1'b0;
      bad_cmd_q <= 1'b0;
      timeout_q <= 1'b0;
    end else if (err || htif_error) begin
      // After an HTIF error the bridge swallows host bytes until reset.
      state  <= COLLECT;
      err    <= 1'b1;
      in_rdy <= 1'b1;
      cnt    <= '0;
      idle   <= '0;
      idx    <= '0;
      rcnt   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          in_rdy <= 1'b1;
          if (in_fire) begin
            idle <= '0;
            if (cnt == '0) begin
              if (!lut_ok) begin
                bad_cmd_q <= 1'b1;
              end else begin
                in_len   <= lut_in;
                resp_len <= lut_resp;
                if (lut_in == CNT_W'(1)) begin
                  state  <= ARM;
                  in_rdy <= 1'b0;
                end else begin
                  cnt <= CNT_W'(1);
                end
              end
            end else if (cnt + CNT_W'(1) == in_len) begin
              state  <= ARM;
              in_rdy <= 1'b0;
              cnt    <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else if (cnt != '0) begin
            if (idle == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
              cnt       <= '0;
              idle      <= '0;
              timeout_q <= 1'b1;
            end else begin
              idle <= idle + IDLE_W'(1);
            end
          end
        end
        ARM: begin
          if (nib_out_rdy) begin
            state <= STREAM;
            idx   <= '0;
          end
        end
        STREAM: begin
          // HTIF treats any bubble as an error, so its ready is not consulted
          // once the stream has started.
          if (idx == last_idx) begin
            state <= RESP;
            idx   <= '0;
            rcnt  <= '0;
          end else begin
            idx <= idx + (CNT_W + 1)'(1);
          end
        end
        RESP: begin
          if (out_fire) begin
            if (rcnt + CNT_W'(1) == resp_len) begin
              state  <= COLLECT;
              in_rdy <= 1'b1;
              rcnt   <= '0;
            end else begin
              rcnt <= rcnt + CNT_W'(1);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // Assembler runs in every state so no response nibble is ever lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_nib   <= '0;
      have_lo  <= 1'b0;
      out_data <= '0;
      out_val  <= 1'b0;
    end else begin
      if (out_fire) begin
        out_val <= 1'b0;
      end
      if (nib_fire) begin
        if (!have_lo) begin
          lo_nib  <= nib_in_bits;
          have_lo <= 1'b1;
        end else begin
          out_data <= {nib_in_bits, lo_nib};
          out_val  <= 1'b1;
          have_lo  <= 1'b0;
        end
      end
    end
  end

  assign cur_byte      = pkt_buf[idx[CNT_W:1]];
  assign nib_out_val   = (state == STREAM);
  assign nib_out_bits  = (state != STREAM) ? 4'h0 :
                         (idx[0] ? cur_byte[7:4] : cur_byte[3:0]);
  assign nib_in_rdy    = !rst && (!out_val || host_out_rdy);
  assign host_in_rdy   = in_rdy;
  assign host_out_val  = out_val;
  assign host_out_data = out_data;
  assign bad_cmd       = bad_cmd_q;
  assign timeout       = timeout_q;
  assign busy          = (state != COLLECT);

endmodule

// File: tb/tb_htif_host_bridge.sv
// tb_htif_host_bridge
//   Scoreboard bench for htif_host_bridge. Stimulus pushes the expected
//   nibble stream and packet lengths when a packet is complete; an HTIF
//   responder model answers each finished stream with random bytes and
//   pushes them as expected host bytes; monitors pop and compare.
module tb_htif_host_bridge;

  localparam int unsigned TO = 1024;

  logic       clk;
  logic       rst;
  logic       host_in_val;
  logic [7:0] host_in_data;
  logic       host_in_rdy;
  logic       host_out_val;
  logic [7:0] host_out_data;
  logic       host_out_rdy;
  logic       nib_out_val;
  logic [3:0] nib_out_bits;
  logic       nib_out_rdy;
  logic       nib_in_val;
  logic [3:0] nib_in_bits;
  logic       nib_in_rdy;
  logic       htif_error;
  logic       bad_cmd;
  logic       timeout;
  logic       busy;

  htif_host_bridge #(
    .MAX_PKT_BYTES (21),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .host_in_val  (host_in_val),
    .host_in_data (host_in_data),
    .host_in_rdy  (host_in_rdy),
    .host_out_val (host_out_val),
    .host_out_data(host_out_data),
    .host_out_rdy (host_out_rdy),
    .nib_out_val  (nib_out_val),
    .nib_out_bits (nib_out_bits),
    .nib_out_rdy  (nib_out_rdy),
    .nib_in_val   (nib_in_val),
    .nib_in_bits  (nib_in_bits),
    .nib_in_rdy   (nib_in_rdy),
    .htif_error   (htif_error),
    .bad_cmd      (bad_cmd),
    .timeout      (timeout),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference length table indexed by command
  int unsigned in_len_tab   [6] = '{5, 21, 5, 9, 5, 1};
  int unsigned resp_len_tab [6] = '{17, 1, 5, 1, 1, 1};

  typedef struct { int unsigned nnib; int unsigned rlen; } pkt_t;
  typedef struct { logic [7:0] data; bit last; } rb_t;

  logic [3:0]  exp_nib [$];
  pkt_t        exp_pkt [$];
  int unsigned resp_jobs [$];
  rb_t         exp_host [$];
  logic [7:0]  pkt [$];
  int unsigned outstanding = 0;
  bit          hold_low = 1'b0;
  bit          resp_active = 1'b0;

  int unsigned checks = 0;
  int unsigned failures = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic void flag_fail(string name, string what);
    checks++;
    failures++;
    $display("FAIL %s %s", name, what);
  endfunction

  function automatic void clear_sb();
    exp_nib.delete();
    exp_pkt.delete();
    resp_jobs.delete();
    exp_host.delete();
    outstanding = 0;
  endfunction

  // random host/HTIF ready behaviour
  always @(negedge clk) begin
    host_out_rdy = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    nib_out_rdy  = ($urandom_range(0, 2) == 0);
  end

  // request-nibble monitor
  initial begin
    int unsigned run;
    pkt_t p;
    run = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst || htif_error) begin
        run = 0;
      end else if (nib_out_val) begin
        if (exp_nib.size() == 0) flag_fail("nib_unexpected", $sformatf("actual=%0h required=none", nib_out_bits));
        else check("nib_bits", nib_out_bits, exp_nib.pop_front());
        run++;
      end else if (run > 0) begin
        if (exp_pkt.size() != 0) begin
          p = exp_pkt.pop_front();
          check("stream_len", run, p.nnib);
          resp_jobs.push_back(p.rlen);
        end
        run = 0;
      end
    end
  end

  // response-byte monitor and one-outstanding check
  initial begin
    rb_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && outstanding > 0) check("in_rdy_while_busy", host_in_rdy, 1'b0);
      if (!rst && host_out_val && host_out_rdy) begin
        if (exp_host.size() == 0) flag_fail("resp_unexpected", $sformatf("actual=%0h required=none", host_out_data));
        else begin
          e = exp_host.pop_front();
          check("resp_byte", host_out_data, e.data);
          if (e.last && outstanding > 0) outstanding--;
        end
      end
    end
  end

  task automatic drive_nib(input logic [3:0] v);
    bit done;
    done = 1'b0;
    nib_in_val  = 1'b1;
    nib_in_bits = v;
    for (int i = 0; i < 300 && !done; i++) begin
      #1;
      if (nib_in_rdy) done = 1'b1;
      @(negedge clk);
    end
    if (!done) flag_fail("nib_in_handshake", "actual=stalled required=accepted");
  endtask

  // HTIF responder model
  initial begin
    int unsigned n;
    logic [7:0] b [$];
    nib_in_val  = 1'b0;
    nib_in_bits = '0;
    forever begin
      @(negedge clk);
      if (resp_jobs.size() > 0 && !rst) begin
        resp_active = 1'b1;
        n = resp_jobs.pop_front();
        b.delete();
        for (int unsigned i = 0; i < n; i++) begin
          b.push_back(8'($urandom));
          exp_host.push_back('{b[i], i == n - 1});
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        for (int unsigned i = 0; i < n; i++) begin
          drive_nib(b[i][3:0]);
          if ($urandom_range(0, 3) == 0) begin
            nib_in_val = 1'b0;
            @(negedge clk);
          end
          drive_nib(b[i][7:4]);
        end
        nib_in_val  = 1'b0;
        resp_active = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] v);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    host_in_val  = 1'b1;
    host_in_data = v;
    for (int i = 0; i < 4000 && !ok; i++) begin
      #1;
      if (host_in_rdy) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      flag_fail("send_byte", "actual=not_ready required=accepted");
    end
    host_in_val = 1'b0;
  endtask

  task automatic build_pkt(input logic [7:0] cmd, input bit zero_payload);
    pkt.delete();
    pkt.push_back(cmd);
    for (int unsigned i = 1; i < in_len_tab[cmd]; i++)
      pkt.push_back(zero_payload ? 8'h00 : 8'($urandom));
  endtask

  task automatic send_pkt(input int unsigned gap);
    for (int i = 0; i < pkt.size(); i++) begin
      send_byte(pkt[i]);
      if (i != pkt.size() - 1) repeat (gap) @(posedge clk);
    end
    foreach (pkt[i]) begin
      exp_nib.push_back(pkt[i][3:0]);
      exp_nib.push_back(pkt[i][7:4]);
    end
    exp_pkt.push_back('{2 * pkt.size(), resp_len_tab[pkt[0]]});
    outstanding++;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (exp_nib.size() == 0 && exp_pkt.size() == 0 && resp_jobs.size() == 0 &&
          exp_host.size() == 0 && outstanding == 0 && !resp_active) done = 1'b1;
    end
    if (!done) flag_fail(name, "actual=pending required=drained");
    repeat (2) @(negedge clk);
    #3;
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_in_rdy"}, host_in_rdy, 1'b1);
  endtask

  task automatic wait_nib_val(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      #3;
      if (nib_out_val) seen = 1'b1;
    end
    if (!seen) flag_fail(name, "actual=no_stream required=stream");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_sb();
    @(negedge clk);
    #3;
    check("rst_in_rdy", host_in_rdy, 1'b0);
    check("rst_nib_in_rdy", nib_in_rdy, 1'b0);
    check("rst_nib_out_val", nib_out_val, 1'b0);
    check("rst_host_out_val", host_out_val, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_bad_cmd", bad_cmd, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #3;
    check("post_rst_in_rdy", host_in_rdy, 1'b1);
  endtask

  initial begin
    rst          = 1'b1;
    host_in_val  = 1'b0;
    host_in_data = '0;
    htif_error   = 1'b0;

    do_reset();

    // start packet, all-zero payload
    build_pkt(8'd4, 1'b1);
    send_pkt(0);
    wait_idle("start_pkt");

    // write_mem with 3-cycle gaps between bytes
    build_pkt(8'd1, 1'b0);
    send_pkt(3);
    wait_idle("wr_mem_gaps");

    // rd_cr immediately followed by another packet
    build_pkt(8'd2, 1'b0);
    send_pkt(0);
    build_pkt(8'd3, 1'b0);
    send_pkt(0);
    wait_idle("back_to_back");

    // unknown command is dropped, next byte is a fresh command
    send_byte(8'h09);
    repeat (2) @(negedge clk);
    #3;
    check("bad_cmd_set", bad_cmd, 1'b1);
    check("bad_cmd_busy", busy, 1'b0);
    check("bad_cmd_in_rdy", host_in_rdy, 1'b1);
    build_pkt(8'd5, 1'b0);
    send_pkt(0);
    wait_idle("stop_after_bad");

    // partial packet timeout
    send_byte(8'h00);
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    repeat (TO - 10) @(posedge clk);
    #1;
    check("timeout_early", timeout, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("timeout_set", timeout, 1'b1);
    check("timeout_busy", busy, 1'b0);
    build_pkt(8'd0, 1'b0);
    send_pkt(0);
    wait_idle("after_timeout");

    // random packets
    for (int k = 0; k < 8; k++) begin
      build_pkt(8'($urandom_range(0, 5)), 1'b0);
      send_pkt($urandom_range(0, 2));
      wait_idle("random_pkt");
    end

    // host stalls on the response
    hold_low = 1'b1;
    build_pkt(8'd0, 1'b0);
    send_pkt(0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 500 && !seen; i++) begin
        @(negedge clk);
        #3;
        if (host_out_val) seen = 1'b1;
      end
      if (!seen) flag_fail("hold_resp", "actual=no_byte required=byte");
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #3;
      check("hold_nib_in_rdy", nib_in_rdy, 1'b0);
      check("hold_out_val", host_out_val, 1'b1);
      if (exp_host.size() > 0) check("hold_out_data", host_out_data, exp_host[0].data);
    end
    hold_low = 1'b0;
    wait_idle("hold_drain");

    // reset in the middle of a stream
    build_pkt(8'd1, 1'b0);
    send_pkt(0);
    wait_nib_val("mid_stream_start");
    repeat (3) @(negedge clk);
    do_reset();
    check("mid_rst_nib_out_val", nib_out_val, 1'b0);
    build_pkt(8'd2, 1'b0);
    send_pkt(1);
    wait_idle("after_mid_rst");

    // HTIF error in the middle of a stream
    build_pkt(8'd4, 1'b0);
    send_pkt(0);
    wait_nib_val("err_stream_start");
    @(negedge clk);
    htif_error = 1'b1;
    clear_sb();
    @(negedge clk);
    htif_error = 1'b0;
    #3;
    check("err_nib_out_val", nib_out_val, 1'b0);
    check("err_busy", busy, 1'b0);
    check("err_in_rdy", host_in_rdy, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(i == 0 ? 8'd5 : 8'($urandom));
    repeat (20) @(negedge clk);
    #3;
    check("err_drop_in_rdy", host_in_rdy, 1'b1);
    check("err_drop_busy", busy, 1'b0);

    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
